// File: rtl/renode_axi_pkg.sv
// Shared AXI burst/response types, encodings and FSM states for the Renode AXI link blocks.
package renode_axi_pkg;

  typedef logic [7:0] burst_length_t;
  typedef logic [2:0] burst_size_t;
  typedef logic [1:0] burst_type_t;
  typedef logic [1:0] response_t;

  localparam burst_type_t BURST_FIXED = 2'b00;
  localparam burst_type_t BURST_INCR  = 2'b01;
  localparam burst_type_t BURST_WRAP  = 2'b10;
  localparam burst_type_t BURST_RSVD  = 2'b11;

  localparam response_t RESP_OKAY   = 2'b00;
  localparam response_t RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  // WRAP bursts are only legal for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_legal(input burst_length_t len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/renode_axi_burst_addr_gen.sv
// Next-beat address for FIXED/INCR/WRAP bursts plus burst legality check.
// Latency: purely combinational.
// Backpressure: none; the owning FSM decides when to advance.
module renode_axi_burst_addr_gen
  import renode_axi_pkg::*;
#(
  parameter int AddressWidth = 64,
  parameter int StrobeWidth  = 8
) (
  input  logic [AddressWidth-1:0] addr,
  input  burst_length_t           len,
  input  burst_size_t             size,
  input  burst_type_t             burst,
  output logic [AddressWidth-1:0] next_addr,
  output logic                    burst_err
);

  localparam int MaxSize = $clog2(StrobeWidth);

  logic [AddressWidth-1:0] step;
  logic [AddressWidth-1:0] wrap_mask;

  always_comb begin
    step      = AddressWidth'(1) << size;
    wrap_mask = ((AddressWidth'(len) + AddressWidth'(1)) << size) - AddressWidth'(1);
    next_addr = addr;
    case (burst)
      BURST_INCR: next_addr = (addr & ~(step - AddressWidth'(1))) + step;
      BURST_WRAP: next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
      default:    next_addr = addr;
    endcase
    burst_err = (int'(size) > MaxSize) || (burst == BURST_RSVD) ||
                ((burst == BURST_WRAP) && !wrap_len_legal(len));
  end

endmodule

// File: rtl/renode_axi_mem_responder.sv
// AXI4 subordinate terminating bursts into a local word-addressed memory.
// Latency: wready/rvalid(beat 0) one cycle after AW/AR handshake; bvalid one cycle after last W beat.
// Backpressure: one burst per direction in flight; B and R outputs held stable until bready/rready.
module renode_axi_mem_responder
  import renode_axi_pkg::*;
#(
  parameter int                    AddressWidth       = 64,
  parameter int                    DataWidth          = 64,
  parameter int                    TransactionIdWidth = 8,
  parameter int                    MemDepthWords      = 1024,
  parameter logic [AddressWidth-1:0] BaseAddress      = '0,
  localparam int                   StrobeWidth        = DataWidth / 8
) (
  input  logic                          aclk,
  input  logic                          areset_n,

  input  logic [TransactionIdWidth-1:0] awid,
  input  logic [AddressWidth-1:0]       awaddr,
  input  logic [7:0]                    awlen,
  input  logic [2:0]                    awsize,
  input  logic [1:0]                    awburst,
  input  logic                          awlock,
  input  logic [3:0]                    awcache,
  input  logic [2:0]                    awprot,
  input  logic                          awvalid,
  output logic                          awready,

  input  logic [DataWidth-1:0]          wdata,
  input  logic [StrobeWidth-1:0]        wstrb,
  input  logic                          wlast,
  input  logic                          wvalid,
  output logic                          wready,

  output logic [TransactionIdWidth-1:0] bid,
  output logic [1:0]                    bresp,
  output logic                          bvalid,
  input  logic                          bready,

  input  logic [TransactionIdWidth-1:0] arid,
  input  logic [AddressWidth-1:0]       araddr,
  input  logic [7:0]                    arlen,
  input  logic [2:0]                    arsize,
  input  logic [1:0]                    arburst,
  input  logic                          arlock,
  input  logic [3:0]                    arcache,
  input  logic [2:0]                    arprot,
  input  logic                          arvalid,
  output logic                          arready,

  output logic [TransactionIdWidth-1:0] rid,
  output logic [DataWidth-1:0]          rdata,
  output logic [1:0]                    rresp,
  output logic                          rlast,
  output logic                          rvalid,
  input  logic                          rready
);

  localparam int WordShift = $clog2(StrobeWidth);
  localparam int IdxWidth  = (MemDepthWords > 1) ? $clog2(MemDepthWords) : 1;

  typedef struct packed {
    logic [TransactionIdWidth-1:0] id;
    logic [AddressWidth-1:0]       addr;
    burst_length_t                 len;
    burst_size_t                   size;
    burst_type_t                   burst;
  } burst_t;

  function automatic logic addr_in_range(input logic [AddressWidth-1:0] a);
    return (a >= BaseAddress) &&
           (((a - BaseAddress) >> WordShift) < AddressWidth'(MemDepthWords));
  endfunction

  function automatic logic [IdxWidth-1:0] word_idx(input logic [AddressWidth-1:0] a);
    return IdxWidth'((a - BaseAddress) >> WordShift);
  endfunction

  logic [DataWidth-1:0] mem [MemDepthWords];

  wr_state_t     wr_state;
  burst_t        wr;
  burst_length_t wr_cnt;
  logic          wr_err;

  rd_state_t     rd_state;
  burst_t        rd;
  burst_t        r_gen;
  burst_length_t rd_cnt;

  logic [AddressWidth-1:0] w_next_addr;
  logic [AddressWidth-1:0] r_next_addr;
  logic [AddressWidth-1:0] r_beat_addr;
  logic                    w_burst_err;
  logic                    r_burst_err;
  logic                    w_hs;
  logic                    w_last_beat;
  logic                    w_beat_err;
  logic                    w_commit;
  logic [IdxWidth-1:0]     w_idx;
  logic                    r_beat_ok;
  logic [DataWidth-1:0]    r_beat_data;

  renode_axi_burst_addr_gen #(
    .AddressWidth (AddressWidth),
    .StrobeWidth  (StrobeWidth)
  ) u_wr_addr_gen (
    .addr      (wr.addr),
    .len       (wr.len),
    .size      (wr.size),
    .burst     (wr.burst),
    .next_addr (w_next_addr),
    .burst_err (w_burst_err)
  );

  // While idle the read generator checks the incoming AR so beat 0 can be
  // produced directly from the handshake cycle.
  always_comb begin
    if (rd_state == R_IDLE) begin
      r_gen = '{id: arid, addr: araddr, len: arlen, size: arsize, burst: arburst};
    end else begin
      r_gen = rd;
    end
  end

  renode_axi_burst_addr_gen #(
    .AddressWidth (AddressWidth),
    .StrobeWidth  (StrobeWidth)
  ) u_rd_addr_gen (
    .addr      (r_gen.addr),
    .len       (r_gen.len),
    .size      (r_gen.size),
    .burst     (r_gen.burst),
    .next_addr (r_next_addr),
    .burst_err (r_burst_err)
  );

  assign w_hs        = (wr_state == W_DATA) && wready && wvalid;
  assign w_last_beat = (wr_cnt == wr.len);
  assign w_beat_err  = w_burst_err || !addr_in_range(wr.addr);
  assign w_commit    = w_hs && !w_beat_err;
  assign w_idx       = word_idx(wr.addr);

  assign r_beat_addr = (rd_state == R_IDLE) ? araddr : r_next_addr;
  assign r_beat_ok   = !r_burst_err && addr_in_range(r_beat_addr);
  assign r_beat_data = mem[word_idx(r_beat_addr)];

  always_ff @(posedge aclk) begin
    if (w_commit) begin
      for (int b = 0; b < StrobeWidth; b++) begin
        if (wstrb[b]) mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_state <= W_IDLE;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bid      <= '0;
      bresp    <= RESP_OKAY;
      wr       <= '0;
      wr_cnt   <= '0;
      wr_err   <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (awready && awvalid) begin
            awready  <= 1'b0;
            wready   <= 1'b1;
            wr       <= '{id: awid, addr: awaddr, len: awlen, size: awsize, burst: awburst};
            wr_cnt   <= '0;
            wr_err   <= 1'b0;
            wr_state <= W_DATA;
          end else begin
            awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            wr.addr <= w_next_addr;
            wr_cnt  <= wr_cnt + 8'd1;
            // awlen sets the beat count; wlast is only checked against it.
            if (w_last_beat) begin
              wready   <= 1'b0;
              bvalid   <= 1'b1;
              bid      <= wr.id;
              bresp    <= (wr_err || w_beat_err || !wlast) ? RESP_SLVERR : RESP_OKAY;
              wr_state <= W_RESP;
            end else begin
              wr_err <= wr_err || w_beat_err || wlast;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid   <= 1'b0;
            awready  <= 1'b1;
            wr_state <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      rd_state <= R_IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rid      <= '0;
      rresp    <= RESP_OKAY;
      rdata    <= '0;
      rd       <= '0;
      rd_cnt   <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (arready && arvalid) begin
            arready  <= 1'b0;
            rvalid   <= 1'b1;
            rid      <= arid;
            rlast    <= (arlen == 8'd0);
            rd       <= r_gen;
            rd_cnt   <= '0;
            rdata    <= r_beat_ok ? r_beat_data : '0;
            rresp    <= r_beat_ok ? RESP_OKAY : RESP_SLVERR;
            rd_state <= R_DATA;
          end else begin
            arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid   <= 1'b0;
              rlast    <= 1'b0;
              arready  <= 1'b1;
              rd_state <= R_IDLE;
            end else begin
              rd.addr <= r_next_addr;
              rd_cnt  <= rd_cnt + 8'd1;
              rlast   <= ((rd_cnt + 8'd1) == rd.len);
              rdata   <= r_beat_ok ? r_beat_data : '0;
              rresp   <= r_beat_ok ? RESP_OKAY : RESP_SLVERR;
            end
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, awlock, awcache, awprot, arlock, arcache, arprot, rd.id};

endmodule

// File: tb/tb_renode_axi_mem_responder.sv
// Directed table-driven bench for renode_axi_mem_responder (64-bit data, 1024 words, base 0).
module tb_renode_axi_mem_responder;
  import renode_axi_pkg::*;

  logic        aclk = 1'b0;
  logic        areset_n = 1'b0;
  logic [7:0]  awid = '0, arid = '0, bid, rid;
  logic [63:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [7:0]  awlen = '0, arlen = '0, wstrb = '0;
  logic [2:0]  awsize = '0, arsize = '0, awprot = '0, arprot = '0;
  logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
  logic [3:0]  awcache = '0, arcache = '0;
  logic        awlock = 1'b0, arlock = 1'b0;
  logic        awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
  logic        bvalid, bready = 1'b0, arvalid = 1'b0, arready;
  logic        rlast, rvalid, rready = 1'b0;

  renode_axi_mem_responder dut (
    .aclk(aclk), .areset_n(areset_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  logic [63:0] wd [16];
  logic [7:0]  ws [16];
  bit          wlast_all = 1'b0;
  logic [63:0] exp_d [16];
  logic [1:0]  exp_r;

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  size;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [1:0]  exp_bresp;
    logic [63:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  task automatic write_burst(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int bdelay,
                             input logic [1:0] exp_resp);
    int n;
    @(negedge aclk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge aclk); n++; end
    if (!awready) note_timeout("aw_timeout");
    @(negedge aclk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wd[i]; wstrb = ws[i]; wlast = wlast_all || (i == int'(len)); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin @(negedge aclk); n++; end
      if (!wready) note_timeout("w_timeout");
      @(negedge aclk);
    end
    wvalid = 1'b0;
    wlast = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge aclk); n++; end
    if (!bvalid) note_timeout("b_timeout");
    for (int d = 0; d < bdelay; d++) begin
      check("b_hold_bvalid", 64'(bvalid), 64'd1);
      check("b_hold_bid", 64'(bid), 64'(id));
      check("b_hold_awready", 64'(awready), 64'd0);
      @(negedge aclk);
    end
    check("bid", 64'(bid), 64'(id));
    check("bresp", 64'(bresp), 64'(exp_resp));
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    check("bvalid_clear", 64'(bvalid), 64'd0);
  endtask

  task automatic read_burst(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit toggle);
    int n, beats, guard;
    bit seen_last;
    @(negedge aclk);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge aclk); n++; end
    if (!arready) note_timeout("ar_timeout");
    @(negedge aclk);
    arvalid = 1'b0;
    beats = 0;
    guard = 0;
    seen_last = 1'b0;
    while (!seen_last && guard < 200) begin
      rready = toggle ? guard[0] : 1'b1;
      if (rvalid) begin
        check("rdata", rdata, (beats < 16) ? exp_d[beats] : 64'h0);
        check("rresp", 64'(rresp), 64'(exp_r));
        check("rid", 64'(rid), 64'(id));
        check("rlast", 64'(rlast), 64'(beats == int'(len)));
        if (rready) begin
          beats++;
          seen_last = rlast;
        end
      end
      @(negedge aclk);
      guard++;
    end
    rready = 1'b0;
    if (!seen_last) note_timeout("r_timeout");
    check("r_beats", 64'(beats), 64'(int'(len) + 1));
    check("rvalid_clear", 64'(rvalid), 64'd0);
  endtask

  initial begin
    int n;
    vecs[0] = '{64'h200,  3'd3, 64'h0000_0000_0000_0000, 8'hFF, RESP_OKAY,   64'h0000_0000_0000_0000, RESP_OKAY};
    vecs[1] = '{64'h200,  3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, RESP_OKAY,   64'h0000_0000_FFFF_FFFF, RESP_OKAY};
    vecs[2] = '{64'h200,  3'd3, 64'h1122_3344_5566_7788, 8'hF0, RESP_OKAY,   64'h1122_3344_FFFF_FFFF, RESP_OKAY};
    vecs[3] = '{64'h200,  3'd3, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00, RESP_OKAY,   64'h1122_3344_FFFF_FFFF, RESP_OKAY};
    vecs[4] = '{64'h1FF8, 3'd3, 64'h0123_4567_89AB_CDEF, 8'hFF, RESP_OKAY,   64'h0123_4567_89AB_CDEF, RESP_OKAY};
    vecs[5] = '{64'h2000, 3'd3, 64'h5555_5555_5555_5555, 8'hFF, RESP_SLVERR, 64'h0000_0000_0000_0000, RESP_SLVERR};
    vecs[6] = '{64'h200,  3'd4, 64'h9999_9999_9999_9999, 8'hFF, RESP_SLVERR, 64'h0000_0000_0000_0000, RESP_SLVERR};
    vecs[7] = '{64'h204,  3'd2, 64'hCAFE_BABE_1234_5678, 8'hF0, RESP_OKAY,   64'hCAFE_BABE_FFFF_FFFF, RESP_OKAY};

    repeat (3) @(negedge aclk);
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rlast", 64'(rlast), 64'd0);
    check("rst_bid", 64'(bid), 64'd0);
    check("rst_bresp", 64'(bresp), 64'd0);
    check("rst_rid", 64'(rid), 64'd0);
    check("rst_rresp", 64'(rresp), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    areset_n = 1'b1;
    #1;
    check("rel_awready_before_edge", 64'(awready), 64'd0);
    @(negedge aclk);
    check("rel_awready", 64'(awready), 64'd1);
    check("rel_arready", 64'(arready), 64'd1);

    // 4-beat INCR write then read back.
    wd[0] = 64'h11; wd[1] = 64'h22; wd[2] = 64'h33; wd[3] = 64'h44;
    for (int i = 0; i < 4; i++) ws[i] = 8'hFF;
    write_burst(8'd5, 64'h100, 8'd3, 3'd3, BURST_INCR, 0, RESP_OKAY);
    exp_d[0] = 64'h11; exp_d[1] = 64'h22; exp_d[2] = 64'h33; exp_d[3] = 64'h44;
    exp_r = RESP_OKAY;
    read_burst(8'd7, 64'h100, 8'd3, 3'd3, BURST_INCR, 1'b0);

    // WRAP read starting mid-window: 0x118, 0x100, 0x108, 0x110.
    exp_d[0] = 64'h44; exp_d[1] = 64'h11; exp_d[2] = 64'h22; exp_d[3] = 64'h33;
    read_burst(8'd8, 64'h118, 8'd3, 3'd3, BURST_WRAP, 1'b0);

    for (int v = 0; v < 8; v++) begin
      wd[0] = vecs[v].wdata;
      ws[0] = vecs[v].wstrb;
      write_burst(8'(16 + v), vecs[v].addr, 8'd0, vecs[v].size, BURST_INCR, 0, vecs[v].exp_bresp);
      exp_d[0] = vecs[v].exp_rdata;
      exp_r = vecs[v].exp_rresp;
      read_burst(8'(32 + v), vecs[v].addr, 8'd0, vecs[v].size, BURST_INCR, 1'b0);
    end

    // Read just past the end of memory.
    exp_d[0] = 64'h0; exp_d[1] = 64'h0;
    exp_r = RESP_SLVERR;
    read_burst(8'd9, 64'h2000, 8'd1, 3'd3, BURST_INCR, 1'b0);

    // Reserved burst type must not touch memory.
    wd[0] = 64'hBAD; ws[0] = 8'hFF;
    write_burst(8'd10, 64'h100, 8'd0, 3'd3, BURST_RSVD, 0, RESP_SLVERR);
    exp_d[0] = 64'h11;
    exp_r = RESP_OKAY;
    read_burst(8'd11, 64'h100, 8'd0, 3'd3, BURST_INCR, 1'b0);

    // WRAP with an illegal length.
    exp_d[0] = 64'h0; exp_d[1] = 64'h0; exp_d[2] = 64'h0;
    exp_r = RESP_SLVERR;
    read_burst(8'd12, 64'h100, 8'd2, 3'd3, BURST_WRAP, 1'b0);

    // Backpressure on B and R.
    wd[0] = 64'h77; ws[0] = 8'hFF;
    write_burst(8'h3C, 64'h300, 8'd0, 3'd3, BURST_INCR, 5, RESP_OKAY);
    exp_d[0] = 64'h11; exp_d[1] = 64'h22; exp_d[2] = 64'h33; exp_d[3] = 64'h44;
    exp_r = RESP_OKAY;
    read_burst(8'd13, 64'h100, 8'd3, 3'd3, BURST_INCR, 1'b1);
    exp_d[0] = 64'h77;
    read_burst(8'd14, 64'h300, 8'd0, 3'd3, BURST_INCR, 1'b1);

    // Early wlast on a 2-beat burst.
    wlast_all = 1'b1;
    wd[0] = 64'hA0; wd[1] = 64'hA1; ws[0] = 8'hFF; ws[1] = 8'hFF;
    write_burst(8'd15, 64'h400, 8'd1, 3'd3, BURST_INCR, 0, RESP_SLVERR);
    wlast_all = 1'b0;

    // Reset asserted while beat 2 of a 4-beat read is presented.
    @(negedge aclk);
    arid = 8'd2; araddr = 64'h100; arlen = 8'd3; arsize = 3'd3; arburst = BURST_INCR; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge aclk); n++; end
    if (!arready) note_timeout("rst_ar_timeout");
    @(negedge aclk);
    arvalid = 1'b0;
    rready = 1'b1;
    check("rst_seq_beat0", rdata, 64'h11);
    @(negedge aclk);
    check("rst_seq_beat1", rdata, 64'h22);
    @(negedge aclk);
    check("rst_seq_beat2", rdata, 64'h33);
    areset_n = 1'b0;
    #1;
    check("rst_seq_rvalid", 64'(rvalid), 64'd0);
    check("rst_seq_rlast", 64'(rlast), 64'd0);
    check("rst_seq_rdata", rdata, 64'd0);
    check("rst_seq_arready", 64'(arready), 64'd0);
    @(negedge aclk);
    rready = 1'b0;
    areset_n = 1'b1;
    #1;
    check("rst_seq_arready_at_release", 64'(arready), 64'd0);
    @(negedge aclk);
    check("rst_seq_arready_after", 64'(arready), 64'd1);
    check("rst_seq_awready_after", 64'(awready), 64'd1);
    exp_d[0] = 64'h11; exp_d[1] = 64'h22;
    exp_r = RESP_OKAY;
    read_burst(8'd3, 64'h100, 8'd1, 3'd3, BURST_INCR, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/renode_axi_mem_responder.md
# renode_axi_mem_responder

AXI4 subordinate (responder) that terminates bursts from a Renode-driven or RTL manager into a local word-addressed memory. It is the counterpart of the manager side of the Renode AXI link and handles full AW/W/B and AR/R handshakes with FIXED, INCR and WRAP bursts. It sits behind the Renode AXI interface in co-simulation benches as the target memory for DUT or Renode traffic.

## Interface

- AddressWidth, 64, AXI address width
- DataWidth, 64, data width; multiple of 8; StrobeWidth = DataWidth/8
- TransactionIdWidth, 8, width of awid/bid/arid/rid
- MemDepthWords, 1024, number of DataWidth words stored
- BaseAddress, 0, byte address of word 0; StrobeWidth-aligned

Ports:

- aclk  in  1  clock; all logic on rising edge
- areset_n  in  1  asynchronous, active-low reset
- awid/awaddr/awlen/awsize/awburst  in  TransactionIdWidth/AddressWidth/8/3/2  write address
- awlock/awcache/awprot  in  1/4/3  accepted and ignored
- awvalid in 1, awready out 1  AW handshake
- wdata/wstrb/wlast  in  DataWidth/StrobeWidth/1  write data
- wvalid in 1, wready out 1  W handshake
- bid/bresp  out  TransactionIdWidth/2  write response
- bvalid out 1, bready in 1  B handshake
- arid/araddr/arlen/arsize/arburst  in  as AW  read address
- arlock/arcache/arprot  in  1/4/3  ignored
- arvalid in 1, arready out 1  AR handshake
- rid/rdata/rresp/rlast  out  TransactionIdWidth/DataWidth/2/1  read data
- rvalid out 1, rready in 1  R handshake

## Operation

- Independent write and read FSMs; one write and one read burst in flight each.
- Write FSM: W_IDLE (awready=1) -> AW handshake latches id/addr/len/size/burst -> W_DATA (wready=1) -> after beat awlen accepted -> W_RESP (bvalid=1) -> B handshake -> W_IDLE.
- Read FSM: R_IDLE (arready=1) -> AR handshake -> R_DATA (rvalid=1, beats 0..arlen, rlast on beat arlen) -> last R handshake -> R_IDLE.
- Word index = (addr - BaseAddress) >> log2(StrobeWidth); in range iff addr >= BaseAddress and index < MemDepthWords.
- Writes update only byte lanes with wstrb set; out-of-range or error-burst beats discarded.
- Burst address step: FIXED constant; INCR next = align(addr, 2^size) + 2^size; WRAP boundary B = (len+1)*2^size, next = (addr & ~(B-1)) | ((addr + 2^size) & (B-1)).
- SLVERR (2'b10) conditions: size > log2(StrobeWidth); burst type 2'b11; WRAP with len not in {1,3,7,15}; beat out of range. Otherwise OKAY (2'b00).
- Write bresp = SLVERR if any beat erred or wlast disagrees with beat count (early or missing wlast); beat count from awlen is authoritative.
- Read erred beats: rdata = 0, rresp SLVERR; burst still runs len+1 beats.
- 4 KB boundary crossing not checked; manager's responsibility.
- Simultaneous write and read to same word in the same cycle: read returns pre-write data.

## Timing

- Reset: awready, wready, bvalid, arready, rvalid, rlast = 0; bid, bresp, rid, rresp, rdata = 0; both FSMs idle. Memory contents not reset.
- awready/arready rise the first cycle after areset_n deasserts.
- AW handshake at t -> wready=1 at t+1; one W beat per cycle while wvalid.
- Last W beat at t -> bvalid=1 at t+1; bid=awid, bresp stable until B handshake; awready=1 the cycle after.
- AR handshake at t -> rvalid=1 with beat 0 at t+1; back-to-back beats under continuous rready.
- rvalid/rdata/rresp/rlast/rid held stable while rready=0; likewise B outputs while bready=0.
- areset_n low mid-burst: immediate return to reset values; partial write beats already committed remain in memory.

## Structure

- Reuse renode_axi_pkg: burst_length_t, burst_size_t, burst_type_t, response_t; add burst-type and response constants (FIXED/INCR/WRAP, OKAY/SLVERR) there if missing.
- Sub-module renode_axi_burst_addr_gen: combinational next-address and burst-legality check, instanced once per FSM.
- Memory as a register array inside the top.

## Test plan

- INCR write awaddr=0x100 len=3 size=3, data 0x11,0x22,0x33,0x44, wstrb=0xFF, awid=5 -> bresp OKAY, bid=5; INCR read same -> those four words, rlast on 4th, rresp OKAY.
- WRAP read araddr=0x118 len=3 size=3 -> beats from 0x118,0x100,0x108,0x110.
- Write 0xFFFF_FFFF_FFFF_FFFF wstrb=0x0F over zeroed word -> read 0x0000_0000_FFFF_FFFF.
- AR at BaseAddress+MemDepthWords*8, len=1 -> two beats rdata 0, rresp SLVERR, rlast on 2nd; AW with awburst=2'b11 -> bresp SLVERR, memory unchanged.
- bready low 5 cycles, rready toggling -> bvalid/bid stable, awready 0 throughout; no R beat lost or duplicated.
- areset_n pulsed during beat 2 of a 4-beat read -> rvalid 0 immediately; arready 1 one cycle after release.
